// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types and constants for the playfield renderer.
// Holds the palette reset image, colour type and flash state encoding.
package tetris_pkg;

  localparam int CODE_W_DEF = 3;

  typedef logic [11:0] rgb12_t;

  typedef enum logic [1:0] {
    IDLE,
    FLASH_ON,
    FLASH_OFF
  } flash_st_e;

  localparam rgb12_t PAL_RST [8] = '{
    12'hFBC, 12'h777, 12'h0F0, 12'hF00,
    12'h00F, 12'hF70, 12'hF90, 12'h707
  };

  // Entries beyond the base eight come up black.
  function automatic rgb12_t pal_rst(input int idx);
    logic [2:0] w_i;
    w_i = idx[2:0];
    return (idx < 8) ? PAL_RST[w_i] : 12'h000;
  endfunction

endpackage

// File: rtl/tetris_field_renderer_palette.sv
// tetris_palette: 2^CODE_W x 12-bit colour register file.
// Ports: i_clk/i_reset, write strobe/addr/data, combinational read.
module tetris_palette
  import tetris_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [CODE_W-1:0] i_waddr,
  input  logic [11:0]       i_wdata,
  input  logic [CODE_W-1:0] i_raddr,
  output logic [11:0]       o_rdata
);

  localparam int DEPTH = 1 << CODE_W;

  rgb12_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[CODE_W'(i)] <= pal_rst(i);
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read sees the pre-write value during a write cycle.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tetris_field_renderer.sv
// tetris_field_renderer: pixel -> playfield cell -> palette colour, with
// frame border and line-clear row flash. Ports: grid, DrawX/Y, vsync,
// palette write port, flash request/mask, flash busy/done, registered RGB.
module tetris_field_renderer
  import tetris_pkg::*;
#(
  parameter int GRID_W        = 10,
  parameter int GRID_H        = 22,
  parameter int HIDDEN_ROWS   = 2,
  parameter int CELL_SHIFT    = 4,
  parameter int ORIGIN_X      = 240,
  parameter int ORIGIN_Y      = 80,
  parameter int CODE_W        = CODE_W_DEF,
  parameter int FLASH_TOGGLES = 6,
  parameter int FLASH_FRAMES  = 4
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic [GRID_W-1:0][GRID_H-1:0][CODE_W-1:0] i_grid,
  input  logic [9:0]                               i_draw_x,
  input  logic [9:0]                               i_draw_y,
  input  logic                                     i_vsync,
  input  logic                                     i_pal_we,
  input  logic [CODE_W-1:0]                        i_pal_addr,
  input  logic [11:0]                              i_pal_data,
  input  logic                                     i_flash_start,
  input  logic [GRID_H-1:0]                        i_flash_rows,
  output logic                                     o_flash_busy,
  output logic                                     o_flash_done,
  output logic [3:0]                               o_red,
  output logic [3:0]                               o_green,
  output logic [3:0]                               o_blue
);

  localparam int CXW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int CYW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int FTW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int TGW = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;

  localparam int FX = GRID_W << CELL_SHIFT;
  localparam int FY = (GRID_H - HIDDEN_ROWS) << CELL_SHIFT;

  localparam logic [11:0] X_LO = 12'(ORIGIN_X);
  localparam logic [11:0] X_HI = 12'(ORIGIN_X + FX);
  localparam logic [11:0] Y_LO = 12'(ORIGIN_Y);
  localparam logic [11:0] Y_HI = 12'(ORIGIN_Y + FY);
  localparam logic [11:0] BW   = 12'(1 << CELL_SHIFT);

  // Flash FSM
  flash_st_e         r_state;
  logic [GRID_H-1:0] r_mask;
  logic [FTW-1:0]    r_fcnt;
  logic [TGW-1:0]    r_tcnt;
  logic              r_busy;
  logic              r_done;
  logic              r_vsync_q;
  logic              w_tick;

  assign w_tick = i_vsync & ~r_vsync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_fcnt    <= '0;
      r_tcnt    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_vsync_q <= 1'b0;
    end else begin
      r_vsync_q <= i_vsync;
      r_done    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // A tick landing with the start is not counted.
          if (i_flash_start) begin
            r_state <= FLASH_ON;
            r_mask  <= i_flash_rows;
            r_fcnt  <= '0;
            r_tcnt  <= '0;
            r_busy  <= 1'b1;
          end
        end
        FLASH_ON, FLASH_OFF: begin
          if (w_tick) begin
            if (r_fcnt == FTW'(FLASH_FRAMES - 1)) begin
              r_fcnt <= '0;
              if (r_tcnt == TGW'(FLASH_TOGGLES - 1)) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_tcnt  <= r_tcnt + 1'b1;
                r_state <= (r_state == FLASH_ON) ? FLASH_OFF
                                                 : FLASH_ON;
              end
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_flash_busy = r_busy;
  assign o_flash_done = r_done;

  // Stage 1: field geometry and cell lookup
  logic [11:0]    w_x;
  logic [11:0]    w_y;
  logic [11:0]    w_dx;
  logic [11:0]    w_dy;
  logic           w_in_field;
  logic           w_near;
  logic [CXW-1:0] w_cx;
  logic [CYW-1:0] w_cy;

  assign w_x = {2'b00, i_draw_x};
  assign w_y = {2'b00, i_draw_y};

  assign w_in_field = (w_x >= X_LO) && (w_x < X_HI) &&
                      (w_y >= Y_LO) && (w_y < Y_HI);

  // Adding the border width avoids negative lower bounds.
  assign w_near = (w_x + BW >= X_LO) && (w_x < X_HI + BW) &&
                  (w_y + BW >= Y_LO) && (w_y < Y_HI + BW);

  // Offsets forced to 0 outside the field so indices never wrap.
  assign w_dx = w_in_field ? (w_x - X_LO) : '0;
  assign w_dy = w_in_field ? (w_y - Y_LO) : '0;
  assign w_cx = CXW'(w_dx >> CELL_SHIFT);
  assign w_cy = CYW'((w_dy >> CELL_SHIFT) + 12'(HIDDEN_ROWS));

  logic              r_in_field;
  logic              r_border;
  logic [CODE_W-1:0] r_code;
  logic              r_flash_w;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_in_field <= 1'b0;
      r_border   <= 1'b0;
      r_code     <= '0;
      r_flash_w  <= 1'b0;
    end else begin
      r_in_field <= w_in_field;
      r_border   <= w_near & ~w_in_field;
      r_code     <= i_grid[w_cx][w_cy];
      r_flash_w  <= w_in_field & (r_state == FLASH_ON) & r_mask[w_cy];
    end
  end

  // Stage 2: palette and colour select
  logic [11:0] w_pal;
  rgb12_t      w_rgb;
  rgb12_t      r_rgb;

  tetris_palette #(
    .CODE_W (CODE_W)
  ) u_pal (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (i_pal_we),
    .i_waddr (i_pal_addr),
    .i_wdata (i_pal_data),
    .i_raddr (r_code),
    .o_rdata (w_pal)
  );

  always_comb begin
    w_rgb = '0;
    unique case (1'b1)
      r_in_field & ~r_flash_w: w_rgb = w_pal;
      r_border | r_flash_w:    w_rgb = 12'hFFF;
      default:                 w_rgb = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_rgb;
    end
  end

  assign o_red   = r_rgb[11:8];
  assign o_green = r_rgb[7:4];
  assign o_blue  = r_rgb[3:0];

endmodule

// File: tb/tb_tetris_field_renderer.sv
// tb_tetris_field_renderer: randomized + directed bench for the renderer.
// Reference model tracks palette, flash tick count and pixel geometry.
module tb_tetris_field_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst = 1'b1;
  logic [9:0]              dx = '0;
  logic [9:0]              dy = '0;
  logic                    vs = 1'b0;
  logic                    we = 1'b0;
  logic [2:0]              pa = '0;
  logic [11:0]             pd = '0;
  logic                    fs = 1'b0;
  logic [21:0]             fr = '0;
  logic [9:0][21:0][2:0]   grid = '0;
  logic                    busy, done;
  logic [3:0]              r, g, b;

  logic [3:0][3:0][2:0]    grid2 = '0;
  logic                    busy2, done2;
  logic [3:0]              r2, g2, b2;

  tetris_field_renderer dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_grid        (grid),
    .i_draw_x      (dx),
    .i_draw_y      (dy),
    .i_vsync       (vs),
    .i_pal_we      (we),
    .i_pal_addr    (pa),
    .i_pal_data    (pd),
    .i_flash_start (fs),
    .i_flash_rows  (fr),
    .o_flash_busy  (busy),
    .o_flash_done  (done),
    .o_red         (r),
    .o_green       (g),
    .o_blue        (b)
  );

  tetris_field_renderer #(
    .GRID_W      (4),
    .GRID_H      (4),
    .HIDDEN_ROWS (0),
    .CELL_SHIFT  (3)
  ) dut2 (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_grid        (grid2),
    .i_draw_x      (dx),
    .i_draw_y      (dy),
    .i_vsync       (1'b0),
    .i_pal_we      (1'b0),
    .i_pal_addr    (3'd0),
    .i_pal_data    (12'h000),
    .i_flash_start (1'b0),
    .i_flash_rows  (4'h0),
    .o_flash_busy  (busy2),
    .o_flash_done  (done2),
    .o_red         (r2),
    .o_green       (g2),
    .o_blue        (b2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [11:0] mpal [8];
  bit          m_busy, m_done, m_prev_v;
  int          m_ticks;
  logic [21:0] m_mask;
  bit          s_in, s_brd, s_white;
  logic [2:0]  s_code;
  logic [11:0] exp_rgb;

  function automatic void model_reset();
    logic [11:0] init [8];
    init = '{12'hFBC, 12'h777, 12'h0F0, 12'hF00,
             12'h00F, 12'hF70, 12'hF90, 12'h707};
    for (int i = 0; i < 8; i++) mpal[3'(i)] = init[3'(i)];
    m_busy = 0; m_done = 0; m_prev_v = 0; m_ticks = 0; m_mask = '0;
    s_in = 0; s_brd = 0; s_white = 0; s_code = '0; exp_rgb = '0;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  function automatic void model_edge();
    int  x, y, cx, cy;
    bit  on, tick;
    if (rst) begin
      model_reset();
      return;
    end
    if (s_white || s_brd) exp_rgb = 12'hFFF;
    else if (s_in)        exp_rgb = mpal[s_code];
    else                  exp_rgb = 12'h000;
    on = m_busy && (((m_ticks / 4) % 2) == 0);
    x = int'(dx);
    y = int'(dy);
    s_in  = (x >= 240) && (x < 400) && (y >= 80) && (y < 400);
    s_brd = !s_in && (x >= 224) && (x < 416) && (y >= 64) && (y < 416);
    s_code = '0;
    s_white = 0;
    if (s_in) begin
      cx = (x - 240) / 16;
      cy = (y - 80) / 16 + 2;
      s_code  = grid[4'(cx)][5'(cy)];
      s_white = on && m_mask[5'(cy)];
    end
    if (we) mpal[pa] = pd;
    m_done = 0;
    tick = vs && !m_prev_v;
    m_prev_v = vs;
    if (!m_busy) begin
      if (fs) begin
        m_busy = 1; m_ticks = 0; m_mask = fr;
      end
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == 24) begin
        m_busy = 0; m_done = 1;
      end
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("rgb", {r, g, b}, exp_rgb);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_done;
    bit  got_done, saw_w, saw_p;
    logic [3:0] gx;
    logic [4:0] gy;

    model_reset();
    rst = 1; dx = 10'd240; dy = 10'd80;
    step();
    chk("rst_rgb", {r, g, b}, 12'h000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    rst = 0;

    step(); step();
    chk("px_origin", {r, g, b}, 12'hFBC);
    dx = 10'd239;
    step(); step();
    chk("px_border_l", {r, g, b}, 12'hFFF);
    dx = 10'd100; dy = 10'd50;
    step(); step();
    chk("px_outside", {r, g, b}, 12'h000);

    grid[9][21] = 3'd3;
    dx = 10'd399; dy = 10'd399;
    step(); step();
    chk("px_last_cell", {r, g, b}, 12'hF00);
    dx = 10'd400;
    step(); step();
    chk("px_border_r", {r, g, b}, 12'hFFF);
    dx = 10'd416;
    step(); step();
    chk("px_past_border", {r, g, b}, 12'h000);

    grid[0][2] = 3'd2;
    dx = 10'd240; dy = 10'd80;
    step(); step();
    chk("pal_before", {r, g, b}, 12'h0F0);
    we = 1; pa = 3'd2; pd = 12'h123;
    step();
    chk("pal_same", {r, g, b}, 12'h0F0);
    we = 0;
    step();
    chk("pal_next", {r, g, b}, 12'h123);

    // Row flash on bottom row
    grid[0][21] = 3'd3;
    dx = 10'd240; dy = 10'd399; vs = 0;
    fr = 22'h200000; fs = 1;
    step();
    fs = 0;
    chk("busy_rise", busy, 1);
    n_done = 0; got_done = 0; saw_w = 0; saw_p = 0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      vs = (c % 6) < 2;
      fs = (c == 50);
      fr = 22'h000001;
      step();
      if ({r, g, b} == 12'hFFF) saw_w = 1;
      if ({r, g, b} == 12'hF00) saw_p = 1;
      if (done) begin
        n_done++; got_done = 1;
        chk("busy_fall", busy, 0);
      end
    end
    fs = 0;
    chk("flash_done_seen", got_done, 1);
    chk("flash_white", saw_w, 1);
    chk("flash_pal", saw_p, 1);
    for (int c = 0; c < 40; c++) begin
      vs = (c % 6) < 2;
      step();
      if (done) n_done++;
    end
    chk("done_once", n_done, 1);

    // Reset in the middle of a flash
    fr = '1; fs = 1;
    step();
    fs = 0;
    for (int c = 0; c < 20; c++) begin
      vs = (c % 6) < 2;
      step();
    end
    chk("mid_busy", busy, 1);
    rst = 1;
    step();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rgb", {r, g, b}, 12'h000);
    chk("rst_mid_done", done, 0);
    rst = 0;
    n_done = 0;
    for (int c = 0; c < 200; c++) begin
      vs = (c % 6) < 2;
      step();
      if (done) n_done++;
    end
    chk("no_done_after_rst", n_done, 0);

    // Small-field configuration
    grid2 = '0;
    grid2[3][3] = 3'd5;
    dx = 10'd271; dy = 10'd111;
    step(); step();
    chk("c2_cell", {r2, g2, b2}, 12'hF70);
    dx = 10'd272;
    step(); step();
    chk("c2_border", {r2, g2, b2}, 12'hFFF);
    dx = 10'd280;
    step(); step();
    chk("c2_outside", {r2, g2, b2}, 12'h000);
    dx = 10'd240; dy = 10'd80;
    step(); step();
    chk("c2_origin", {r2, g2, b2}, 12'hFBC);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      vs = (c % 7) < 3;
      if ($urandom_range(0, 3) == 0) begin
        dx = 10'($urandom_range(0, 1023));
        dy = 10'($urandom_range(0, 1023));
      end else begin
        dx = 10'($urandom_range(216, 424));
        dy = 10'($urandom_range(56, 424));
      end
      gx = 4'($urandom_range(0, 9));
      gy = 5'($urandom_range(0, 21));
      grid[gx][gy] = 3'($urandom);
      we = ($urandom_range(0, 19) == 0);
      pa = 3'($urandom);
      pd = 12'($urandom);
      fs = ($urandom_range(0, 49) == 0);
      fr = 22'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tetris_field_renderer.md
# tetris_field_renderer

Parametrised, pipelined playfield renderer for the HDMI path. It maps each (DrawX, DrawY) pixel to a playfield cell, looks the cell code up in a run-time writable palette, draws a one-cell frame border, and supports a frame-counted row-flash effect for line clears. It sits between the game-state grid and the HDMI encoder, replacing the fixed combinational colour mapping.

## Interface
- GRID_W, 10, playfield columns
- GRID_H, 22, playfield rows including hidden spawn rows
- HIDDEN_ROWS, 2, top rows never drawn
- CELL_SHIFT, 4, log2 of cell edge in pixels (16 px)
- ORIGIN_X, 240, left pixel of visible field
- ORIGIN_Y, 80, top pixel of visible field
- CODE_W, 3, bits per cell code; palette depth = 2^CODE_W
- FLASH_TOGGLES, 6, number of on/off half-periods per flash
- FLASH_FRAMES, 4, frames per half-period
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high
- grid  in  [GRID_W][GRID_H] x CODE_W  cell codes, grid[x][y], y=0 top
- DrawX, DrawY  in  10 each  current pixel coordinate
- vsync  in  1  frame sync from VGA controller; rising edge = frame tick
- pal_we  in  1  palette write strobe
- pal_addr  in  CODE_W  palette entry
- pal_data  in  12  {R,G,B} 4 bits each
- flash_start  in  1  one-cycle request to flash rows in flash_rows
- flash_rows  in  GRID_H  row mask, sampled on accepted flash_start
- flash_busy  out  1  high in FLASH_ON/FLASH_OFF
- flash_done  out  1  one-cycle pulse on natural completion
- Red, Green, Blue  out  4 each  registered pixel colour

## Operation
- Visible field: FX = GRID_W<<CELL_SHIFT, FY = (GRID_H-HIDDEN_ROWS)<<CELL_SHIFT; pixel in field iff ORIGIN_X <= DrawX < ORIGIN_X+FX and ORIGIN_Y <= DrawY < ORIGIN_Y+FY.
- Cell: cx = (DrawX-ORIGIN_X)>>CELL_SHIFT, cy = ((DrawY-ORIGIN_Y)>>CELL_SHIFT)+HIDDEN_ROWS; subtraction only evaluated when in field (no wrap indexing).
- Border: pixels within one cell (1<<CELL_SHIFT) outside the field on any side, not in field -> white (F,F,F). All other pixels -> black (0,0,0).
- In field: colour = palette[grid[cx][cy]]; if flash state is FLASH_ON and latched_mask[cy]=1 -> white overrides palette.
- Palette reset contents (R,G,B hex): 0 F,B,C; 1 7,7,7; 2 0,F,0; 3 F,0,0; 4 0,0,F; 5 F,7,0; 6 F,9,0; 7 7,0,7. For CODE_W>3 entries 8+ reset to 0,0,0.
- Palette write is registered; affects pixels looked up from the next cycle on. Same-cycle read of the entry being written returns the old value.
- Flash FSM: IDLE -> FLASH_ON on flash_start (latch flash_rows, clear counters). FLASH_ON <-> FLASH_OFF after FLASH_FRAMES frame ticks each; after FLASH_TOGGLES half-periods -> IDLE with flash_done=1 for one cycle.
- flash_start while busy: ignored, mask unchanged. flash_start with all-zero mask: accepted, runs normally.
- Frame tick = vsync rising edge, detected with one register stage.

## Timing
- Latency 2 Clk: stage 1 registers in_field, border, cx, cy; stage 2 registers Red/Green/Blue. Grid and flash state sampled at stage 1 time.
- Reset: Red/Green/Blue=0, flash_busy=0, flash_done=0, FSM IDLE, mask cleared, counters 0, palette to reset contents, vsync edge register 0; pipeline registers cleared.
- Reset mid-flash: immediate IDLE, no flash_done.
- flash_busy rises the cycle after accepted flash_start; falls the same cycle flash_done pulses.
- Frame tick coincident with flash_start: tick does not count toward the new flash.

## Structure
- Package tetris_pkg: CODE_W default, palette reset constant array, flash state enum (IDLE, FLASH_ON, FLASH_OFF), rgb12_t typedef.
- Sub-module tetris_palette: 2^CODE_W x 12 register file, synchronous write, combinational read, reset loaded from package constant.

## Test plan
- Defaults, grid all 0, DrawX=240,DrawY=80 -> after 2 Clk RGB=F,B,C; DrawX=239 -> F,F,F; DrawX=100,DrawY=50 -> 0,0,0.
- grid[9][21]=3, DrawX=399,DrawY=399 -> F,0,0; DrawX=400 -> F,F,F border; DrawX=416 -> 0,0,0.
- pal_we addr=2 data=0x123, grid cell=2 -> RGB 1,2,3 from next lookup; pixel in same-cycle lookup shows 0,F,0.
- flash_start with mask bit 21, 1 frame tick per 2 test frames scaled: row 21 white in ON, palette in OFF, flash_done pulse after 24 ticks, busy low after.
- Second flash_start mid-flash ignored; Reset mid-flash -> busy 0, no done, RGB 0 on next cycle.
- CELL_SHIFT=3, GRID_W=4, GRID_H=4, HIDDEN_ROWS=0 -> field 32x32 px at origin, cell (3,3) colour at DrawX=271,DrawY=111.
